fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit.sv | 89 ++++++++
 tb/tb_fetch_pc_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Instruction-fetch PC stage of the dual-issue pipeline. It holds one fetch
// PC per cycle and drives the 64-bit instruction SRAM for the word pair at
// PC/PC+4. It presents {discard_current_inst, ce, pc} to decode.
// Sequential fetch advances by 8. Exception redirects (flush) take priority
// over branch redirects (br_bus). A branch that arrives while the PC stage
// is stalled is buffered and applied on the first unstalled edge.
//
// Ports
//   clk              pipeline clock
//   rst              synchronous active-high reset
//   flush            exception/eret redirect; applies even when stalled
//   new_pc[31:0]     flush target
//   stall[5:0]       stall bus; stall[0] stops the PC stage
//   br_bus[32:0]     {br_e, br_addr} from decode, one cycle wide
//   if_to_id_bus     {discard_current_inst, ce, pc} to decode
//   inst_sram_en     fetch enable (= ce)
//   inst_sram_wen    tied to zero (read-only port)
//   inst_sram_addr   current fetch PC
//   inst_sram_wdata  tied to zero

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFF8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [33:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [7:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [63:0] inst_sram_wdata
);

    logic        br_e;
    logic [31:0] br_addr;
    logic        pc_stop;

    logic [31:0] pc_r;
    logic        ce_r;
    logic        pend_v;
    logic [31:0] pend_addr;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign pc_stop = stall[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            ce_r      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'h0;
        end else if (flush) begin
            pc_r   <= new_pc;
            ce_r   <= 1'b1;
            pend_v <= 1'b0;
        end else if (!pc_stop) begin
            ce_r   <= 1'b1;
            pend_v <= 1'b0;
            // A buffered redirect outranks a branch that shows up on the
            // release edge: the buffered one is older in program order.
            if (pend_v) begin
                pc_r <= pend_addr;
            end else if (br_e) begin
                pc_r <= br_addr;
            end else begin
                pc_r <= pc_r + 32'd8;
            end
        end else if (br_e && !pend_v) begin
            // Only the first redirect seen during a stall is kept. Later
            // ones come from instructions that the first one discards.
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end
    end

    // The held pair is stale once a redirect is buffered. Decode drops both
    // slots while discard is high.
    assign if_to_id_bus    = {pend_v, ce_r, pc_r};
    assign inst_sram_en    = ce_r;
    assign inst_sram_wen   = 8'b0;
    assign inst_sram_addr  = pc_r;
    assign inst_sram_wdata = 64'b0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'hBFBF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] new_pc;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [33:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [7:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [63:0] inst_sram_wdata;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch address, enable, and the redirect waiting to be
    // applied once the stall lifts (pend_q holds at most one entry).
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] pend_q[$];
    bit          m_known = 0;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .new_pc          (new_pc),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    task automatic model_edge();
        if (rst) begin
            m_pc = RST_PC;
            m_ce = 1'b0;
            pend_q.delete();
            m_known = 1;
        end else if (flush) begin
            m_pc = new_pc;
            m_ce = 1'b1;
            pend_q.delete();
        end else if (!stall[0]) begin
            m_ce = 1'b1;
            if (pend_q.size() != 0)  m_pc = pend_q.pop_front();
            else if (br_bus[32])     m_pc = br_bus[31:0];
            else                     m_pc = m_pc + 32'd8;
        end else if (br_bus[32] && pend_q.size() == 0) begin
            pend_q.push_back(br_bus[31:0]);
        end
    endtask

    task automatic chk34(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [33:0] exp_bus;
        if (!m_known) return;
        exp_bus = {(pend_q.size() != 0), m_ce, m_pc};
        chk34("bus", if_to_id_bus, exp_bus);
        chk34("en", {33'b0, inst_sram_en}, {33'b0, m_ce});
        chk34("addr", {2'b0, inst_sram_addr}, {2'b0, m_pc});
        chk34("wen", {26'b0, inst_sram_wen}, 34'b0);
        chk34("wdata_or", {33'b0, |inst_sram_wdata}, 34'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        rst = 0; flush = 0; new_pc = 32'h0; stall = 6'b0; br_bus = 33'h0;
    endtask

    // Directed check of the fetch address and discard bit against literal values.
    task automatic expect_pc(input string tag, input logic [31:0] pc, input logic disc, input logic ce);
        chk34(tag, if_to_id_bus, {disc, ce, pc});
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (3) step();
        expect_pc("reset_bus", RST_PC, 1'b0, 1'b0);

        idle();
        step(); expect_pc("seq0", 32'hBFC0_0000, 1'b0, 1'b1);
        step(); expect_pc("seq1", 32'hBFC0_0008, 1'b0, 1'b1);
        step(); expect_pc("seq2", 32'hBFC0_0010, 1'b0, 1'b1);

        br_bus = {1'b1, 32'hBFC0_0104};
        step(); expect_pc("branch", 32'hBFC0_0104, 1'b0, 1'b1);
        idle();
        step(); expect_pc("after_branch", 32'hBFC0_010C, 1'b0, 1'b1);

        flush = 1; new_pc = 32'hBFC0_0020;
        step(); expect_pc("flush_to_20", 32'hBFC0_0020, 1'b0, 1'b1);

        idle(); stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0200};
        step(); expect_pc("stall1", 32'hBFC0_0020, 1'b1, 1'b1);
        br_bus = {1'b1, 32'hBFC0_0300};
        step(); expect_pc("stall2", 32'hBFC0_0020, 1'b1, 1'b1);
        br_bus = 33'h0;
        step(); expect_pc("stall3", 32'hBFC0_0020, 1'b1, 1'b1);
        stall = 6'b0;
        step(); expect_pc("release", 32'hBFC0_0200, 1'b0, 1'b1);

        stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0240};
        step(); expect_pc("pend_set", 32'hBFC0_0200, 1'b1, 1'b1);
        br_bus = 33'h0; flush = 1; new_pc = 32'hBFC0_0380;
        step(); expect_pc("flush_in_stall", 32'hBFC0_0380, 1'b0, 1'b1);
        idle();
        step(); expect_pc("no_stale_jump", 32'hBFC0_0388, 1'b0, 1'b1);

        flush = 1; new_pc = 32'hBFC0_0380; br_bus = {1'b1, 32'hBFC0_0500};
        step(); expect_pc("flush_beats_br", 32'hBFC0_0380, 1'b0, 1'b1);
        idle();
        step(); expect_pc("after_flush_br", 32'hBFC0_0388, 1'b0, 1'b1);

        flush = 1; new_pc = 32'hFFFF_FFF8;
        step(); expect_pc("top_addr", 32'hFFFF_FFF8, 1'b0, 1'b1);
        idle();
        step(); expect_pc("wrap", 32'h0000_0000, 1'b0, 1'b1);

        stall = 6'b000001; br_bus = {1'b1, 32'h0000_1234};
        step(); expect_pc("pend_before_rst", 32'h0000_0000, 1'b1, 1'b1);
        br_bus = 33'h0; rst = 1;
        step(); expect_pc("rst_mid_pend", RST_PC, 1'b0, 1'b0);
        idle();
        step(); expect_pc("post_rst", 32'hBFC0_0000, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            new_pc = $urandom;
            stall  = 6'($urandom);
            br_bus = {($urandom_range(0, 2) == 0), 32'($urandom)};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
